// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the pipeline and muldiv_unit.
// master = pipeline side (drives requests and MTHI/MTLO writes),
// slave  = muldiv_unit side (drives status and the HI/LO registers).
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the architectural HI/LO
// registers. One shift-add (multiply) or restoring shift-subtract (divide)
// step per cycle gives a fixed WIDTH-cycle busy window; divide by zero
// completes immediately with hi = a, lo = all ones and a sticky flag.
// op: 00 MULT, 01 DIV, 10 MULTU, 11 DIVU (op[0] selects divide).
// Build option: define MULDIV_SIGNED_EN to make MULT/DIV signed (magnitude
// datapath plus result negation); when undefined every op is unsigned and
// no sign-correction logic is built.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // control state
    state_t           state;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    // iteration datapath: {acc_hi, acc_lo} is the running product or the
    // partial remainder / quotient pair; opnd is the multiplicand or divisor
    logic             is_div;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    // request decode
    logic             op_div;
    logic             div_zero;
    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // one-step results and the final (sign-corrected) HI/LO values
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

`ifdef MULDIV_SIGNED_EN
    logic             a_neg;
    logic             b_neg;
    logic             neg_lo;
    logic             neg_hi;
    logic [2*WIDTH-1:0] prod;
`endif

    assign op_div   = bus.op[0];
    assign div_zero = op_div && (bus.b == '0);
    assign accept   = (state != RUN) && bus.start;

    // operand magnitudes for the unsigned iteration datapath
    always_comb begin
        // NOTE: every always_comb output gets a value on entry, so no path
        // through the block can leave one unassigned and infer a latch.
`ifdef MULDIV_SIGNED_EN
        a_neg = ~bus.op[1] & bus.a[WIDTH-1];
        b_neg = ~bus.op[1] & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
`else
        a_mag = bus.a;
        b_mag = bus.b;
`endif
    end

    // one multiply or divide iteration on the current accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        if (is_div) begin
            // when the trial subtraction succeeds the true difference is
            // below the divisor, so a WIDTH-bit subtract is exact
            step_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // final result: apply operand signs to the magnitude result
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        prod   = {step_hi, step_lo};
        fin_hi = step_hi;
        fin_lo = step_lo;
        if (is_div) begin
            // quotient negative when signs differ, remainder follows dividend
            if (neg_lo) fin_lo = -step_lo;
            if (neg_hi) fin_hi = -step_hi;
        end else if (neg_lo) begin
            prod   = -{step_hi, step_lo};
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
`else
        fin_hi = step_hi;
        fin_lo = step_lo;
`endif
    end

    // datapath: load magnitudes on an accepted start, iterate while running
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers carry no reset; they are always
        // loaded on an accepted start before any result depends on them.
        if (accept) begin
            is_div <= op_div;
            acc_hi <= '0;
            acc_lo <= op_div ? a_mag : b_mag;
            opnd   <= op_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
`endif
        end else if (state == RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    // control FSM, HI/LO registers and status flags
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values; later assignments below deliberately
        // override earlier ones (operation results beat MTHI/MTLO).
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;

            // MTHI/MTLO only land while no operation is iterating
            if (!busy_r) begin
                if (bus.hi_we) hi_r <= bus.wdata;
                if (bus.lo_we) lo_r <= bus.wdata;
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (div_zero) begin
                            // no iterations: report immediately
                            state  <= DONE;
                            count  <= '0;
                            done_r <= 1'b1;
                            dbz_r  <= 1'b1;
                            hi_r   <= bus.a;
                            lo_r   <= '1;
                        end else begin
                            state  <= RUN;
                            count  <= CW'(WIDTH);
                            busy_r <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        hi_r   <= fin_hi;
                        lo_r   <= fin_lo;
                        if (is_div) dbz_r <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule
